// File: rtl/axi_slave_mem_if.sv
// rtl/axi_slave_mem_if.sv - AXI4 bus bundle between a master and axi_slave_mem
// Ports: none; carries the AW, W, B, AR and R channel signals.
// Modports: master drives requests and ready for B/R, slave drives the responses.
interface axi_slave_mem_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;

    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 responder backed by a word-addressed 32-bit memory
// Ports: clk, rst (async, active-high), bus (axi_slave_mem_if.slave).
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs share one array.
// Optional feature: define AXI_SLV_MEM_WRAP_EN to support WRAP bursts; otherwise WRAP is SLVERR.
module axi_slave_mem #(
    parameter int ID_W  = 4,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    axi_slave_mem_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef AXI_SLV_MEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Per-beat error: bad size, out-of-range word, reserved burst, unsupported/illegal WRAP.
    function automatic logic beat_err(input logic [31:0] addr, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) &&
                  ((addr & ((32'd1 << size) - 32'd1)) == 32'd0);
        return (size > 3'd2) || ({2'b00, addr[31:2]} >= 32'(DEPTH)) || (burst == 2'b11) ||
               (burst == 2'b10 && !(WRAP_EN && wrap_ok));
    endfunction

    // Reserved and unsupported burst types hold the address like FIXED.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        case (burst)
            2'b01:   return addr + step;
            2'b10:   return WRAP_EN ? ((addr & ~mask) | ((addr + step) & mask)) : addr;
            default: return addr;
        endcase
    endfunction

    logic [31:0] mem [DEPTH];

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic     up;   // low during reset and for the first edge after it

    logic [ID_W-1:0] w_id, r_id;
    logic [31:0]     w_addr, r_addr;
    logic [3:0]      w_len, r_len, w_cnt, r_cnt;
    logic [2:0]      w_size, r_size;
    logic [1:0]      w_burst, r_burst;
    logic            w_err;
    logic [31:0]     r_data;
    logic [1:0]      r_resp;
    logic            r_last;

    logic        aw_hs, w_hs, ar_hs, r_hs;
    logic        w_beat_err, ar_err, r_nxt_err;
    logic [31:0] r_nxt;

    assign aw_hs      = (w_state == W_IDLE) && up && bus.AWVALID;
    assign w_hs       = (w_state == W_DATA) && bus.WVALID;
    assign ar_hs      = (r_state == R_IDLE) && up && bus.ARVALID;
    assign r_hs       = (r_state == R_DATA) && bus.RREADY;
    assign w_beat_err = beat_err(w_addr, w_len, w_size, w_burst);
    assign ar_err     = beat_err(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST);
    assign r_nxt      = next_addr(r_addr, r_len, r_size, r_burst);
    assign r_nxt_err  = beat_err(r_nxt, r_len, r_size, r_burst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            up      <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            up      <= 1'b1;
        end
    end

    always_comb begin
        w_next      = w_state;
        r_next      = r_state;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.AWREADY = up;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = 1'b1;
                if (w_hs && w_cnt == w_len) w_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: begin
                bus.ARREADY = up;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                if (r_hs && r_cnt == r_len) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign bus.BID   = (w_state == W_RESP) ? w_id : '0;
    assign bus.BRESP = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
    assign bus.RID   = r_id;
    assign bus.RDATA = r_data;
    assign bus.RRESP = r_resp;
    assign bus.RLAST = r_last;

    // Write channel datapath. WLAST only flags a mismatch; the beat counter ends the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= bus.AWID;
            w_addr  <= bus.AWADDR;
            w_len   <= bus.AWLEN;
            w_size  <= bus.AWSIZE;
            w_burst <= bus.AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 4'd1;
            if (w_beat_err || (bus.WLAST != (w_cnt == w_len))) w_err <= 1'b1;
        end
    end

    // Memory has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_hs && !w_beat_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.WSTRB[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= bus.WDATA[8*b +: 8];
            end
        end
    end

    // Read channel datapath: each beat is pre-registered so R outputs come straight from flops.
    // Same-edge reads of a word being written see the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_resp  <= '0;
            r_last  <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= bus.ARID;
            r_addr  <= bus.ARADDR;
            r_len   <= bus.ARLEN;
            r_size  <= bus.ARSIZE;
            r_burst <= bus.ARBURST;
            r_cnt   <= '0;
            r_data  <= ar_err ? 32'd0 : mem[bus.ARADDR[AW+1:2]];
            r_resp  <= ar_err ? 2'b10 : 2'b00;
            r_last  <= (bus.ARLEN == 4'd0);
        end else if (r_hs && r_cnt != r_len) begin
            r_addr <= r_nxt;
            r_cnt  <= r_cnt + 4'd1;
            r_data <= r_nxt_err ? 32'd0 : mem[r_nxt[AW+1:2]];
            r_resp <= r_nxt_err ? 2'b10 : 2'b00;
            r_last <= (r_cnt + 4'd1 == r_len);
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - scoreboard testbench for axi_slave_mem
module tb_axi_slave_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_slave_mem_if #(.ID_W(4)) bus ();
    axi_slave_mem #(.ID_W(4), .DEPTH(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    b_exp_t      eb;
    r_exp_t      er, cur, snap;
    bit          stall_prev = 1'b0;
    bit          rr_toggle  = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] wd [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] outs();
        return {14'd0, bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP, bus.ARREADY,
                bus.RVALID, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};
    endfunction

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return bus.AWREADY;
            1:       return bus.WREADY;
            default: return bus.ARREADY;
        endcase
    endfunction

    // Waits until the selected ready is seen at a negedge; the handshake then lands on the next posedge.
    task automatic wait_ready(input int sel, input string name);
        int n = 0;
        @(negedge clk);
        while (!sig_of(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
        bus.AWBURST = burst; bus.AWVALID = 1'b1;
        wait_ready(0, "aw");
        bus.AWVALID = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        wait_ready(1, "w");
        bus.WVALID = 1'b0;
    endtask

    task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
        bus.ARBURST = burst; bus.ARVALID = 1'b1;
        wait_ready(2, "ar");
        bus.ARVALID = 1'b0;
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [3:0] strb, input int early, input logic [1:0] resp);
        exp_b.push_back({id, resp});
        aw(id, addr, len, 3'd2, 2'b01);
        for (int i = 0; i <= int'(len); i++) wbeat(wd[i], strb, (i == int'(len)) || (i == early));
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                          input logic last);
        exp_r.push_back({id, data, resp, last});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic release_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.AWVALID = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", {62'd0, bus.AWREADY, bus.ARREADY}, 64'd0);
        @(negedge clk);
        check("ready_after_release", {62'd0, bus.AWREADY, bus.ARREADY}, 64'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.RREADY = 1'b1;
        bus.BREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.RREADY = rr_toggle ? ~bus.RREADY : 1'b1;
        end
    end

    // Monitor: pops expectations on every B/R handshake and checks R stability across stalls.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.BVALID && bus.BREADY) begin
                if (exp_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                else begin
                    eb = exp_b.pop_front();
                    check("b_resp", 64'({bus.BID, bus.BRESP}), 64'(eb));
                end
            end
            if (bus.RVALID) begin
                cur = {bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};
                if (stall_prev) check("r_hold", 64'(cur), 64'(snap));
                if (bus.RREADY) begin
                    if (exp_r.size() == 0) check("r_unexpected", 64'd1, 64'd0);
                    else begin
                        er = exp_r.pop_front();
                        check("r_beat", 64'(cur), 64'(er));
                    end
                end
                stall_prev = !bus.RREADY;
                snap = cur;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.ARVALID = 1'b0;

        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        release_check();

        // Abandon a burst mid-way with a new AW pending, then reset.
        aw(4'hC, 32'h200, 4'd3, 3'd2, 2'b01);
        wbeat(32'h12345678, 4'hF, 1'b0);
        bus.AWVALID = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_midburst_outputs", outs(), 64'd0);
        @(negedge clk);
        check("reset_midburst_outputs2", outs(), 64'd0);
        release_check();

        // INCR write then back-to-back read.
        wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        wr(4'h3, 32'h100, 4'd3, 4'hF, -1, 2'b00);
        push_r(4'h5, 32'h11111111, 2'b00, 1'b0);
        push_r(4'h5, 32'h22222222, 2'b00, 1'b0);
        push_r(4'h5, 32'h33333333, 2'b00, 1'b0);
        push_r(4'h5, 32'h44444444, 2'b00, 1'b1);
        ar(4'h5, 32'h100, 4'd3, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("r_no_bubble", {63'd0, bus.RVALID}, 64'd1);
        end
        @(negedge clk);
        check("r_idle_after_last", {62'd0, bus.RVALID, bus.ARREADY}, 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Strobes with read backpressure.
        wd = '{32'h0, 32'h0, 32'h0, 32'h0};
        wr(4'h1, 32'h0, 4'd1, 4'hF, -1, 2'b00);
        wd[0] = 32'hAABBCCDD;
        wr(4'hA, 32'h0, 4'd0, 4'h5, -1, 2'b00);
        rr_toggle = 1'b1;
        push_r(4'h2, 32'h00BB00DD, 2'b00, 1'b0);
        push_r(4'h2, 32'h00000000, 2'b00, 1'b1);
        ar(4'h2, 32'h0, 4'd1, 3'd2, 2'b01);
        drain();
        rr_toggle = 1'b0;

        // Out-of-range write: SLVERR, memory word 0 (the alias) unchanged.
        wd[0] = 32'hDEADBEEF;
        wr(4'h7, 32'h1000, 4'd0, 4'hF, -1, 2'b10);
        @(negedge clk);
        check("b_valid_after_last_beat", {63'd0, bus.BVALID}, 64'd1);
        @(posedge clk);
        #1;
        push_r(4'h1, 32'h00BB00DD, 2'b00, 1'b1);
        ar(4'h1, 32'h0, 4'd0, 3'd2, 2'b01);
        drain();

        // SIZE=3 read: every beat SLVERR with zero data.
        push_r(4'h4, 32'h0, 2'b10, 1'b0);
        push_r(4'h4, 32'h0, 2'b10, 1'b1);
        ar(4'h4, 32'h100, 4'd1, 3'd3, 2'b01);
        drain();

        // Early WLAST: all four beats accepted, SLVERR.
        wd = '{32'h5, 32'h6, 32'h7, 32'h8};
        wr(4'h6, 32'h140, 4'd3, 4'hF, 1, 2'b10);
        drain();

        // WRAP reads.
        wd = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
        wr(4'h2, 32'h30, 4'd3, 4'hF, -1, 2'b00);
`ifdef AXI_SLV_MEM_WRAP_EN
        push_r(4'h8, 32'hA2A2A2A2, 2'b00, 1'b0);
        push_r(4'h8, 32'hA3A3A3A3, 2'b00, 1'b0);
        push_r(4'h8, 32'hA0A0A0A0, 2'b00, 1'b0);
        push_r(4'h8, 32'hA1A1A1A1, 2'b00, 1'b1);
`else
        push_r(4'h8, 32'h0, 2'b10, 1'b0);
        push_r(4'h8, 32'h0, 2'b10, 1'b0);
        push_r(4'h8, 32'h0, 2'b10, 1'b0);
        push_r(4'h8, 32'h0, 2'b10, 1'b1);
`endif
        ar(4'h8, 32'h38, 4'd3, 3'd2, 2'b10);
        drain();
        push_r(4'h9, 32'h0, 2'b10, 1'b0);
        push_r(4'h9, 32'h0, 2'b10, 1'b0);
        push_r(4'h9, 32'h0, 2'b10, 1'b1);
        ar(4'h9, 32'h38, 4'd2, 3'd2, 2'b10);
        drain();

        // Same-edge write and read of one word: read sees old data, next read sees new.
        wd[0] = 32'h0BADF00D;
        wr(4'h1, 32'h80, 4'd0, 4'hF, -1, 2'b00);
        exp_b.push_back({4'h2, 2'b00});
        push_r(4'h3, 32'h0BADF00D, 2'b00, 1'b1);
        aw(4'h2, 32'h80, 4'd0, 3'd2, 2'b01);
        bus.WDATA = 32'h600DCAFE; bus.WSTRB = 4'hF; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
        bus.ARID = 4'h3; bus.ARADDR = 32'h80; bus.ARLEN = 4'd0; bus.ARSIZE = 3'd2;
        bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        @(negedge clk);
        check("collide_same_edge", {62'd0, bus.WREADY, bus.ARREADY}, 64'd3);
        @(posedge clk);
        #1;
        bus.WVALID = 1'b0;
        bus.ARVALID = 1'b0;
        drain();
        push_r(4'h4, 32'h600DCAFE, 2'b00, 1'b1);
        ar(4'h4, 32'h80, 4'd0, 3'd2, 2'b01);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
